// File: rtl/rank_filter.sv
// Rank filter: buffers an N_PIXELS window, odd-even transposition sorts it, and emits the sample at the requested rank.
// Latency: N_PIXELS+1 cycles after the last sample is accepted to the DSO strobe (one SORT pass per cycle, plus one OUT cycle).
// Backpressure: BUSY is high through SORT and OUT, and DSI is ignored then. Macro RANK_FILTER_RANK_SEL_EN enables RANK; without it the output is the median.
module rank_filter #(
    parameter int WIDTH    = 8,
    parameter int N_PIXELS = 9,                  // odd, 3..25
    parameter int RW       = $clog2(N_PIXELS)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             DSI,
    input  logic [WIDTH-1:0] DI,
    input  logic [RW-1:0]    RANK,
    output logic [WIDTH-1:0] DO,
    output logic             DSO,
    output logic             BUSY
);

    // Pass counter must reach N_PIXELS-1, so size it one step wider than the rank index if needed.
    localparam int PW = $clog2(N_PIXELS + 1);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_SORT = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    localparam logic [RW-1:0] LAST_IDX   = RW'(N_PIXELS - 1);
    localparam logic [RW-1:0] MEDIAN_IDX = RW'((N_PIXELS - 1) / 2);
    localparam logic [PW-1:0] LAST_PASS  = PW'(N_PIXELS - 1);

    logic [1:0]       state;
    logic [RW-1:0]    cnt;
    logic [PW-1:0]    pass_cnt;
    logic [RW-1:0]    rank_q;
    logic [RW-1:0]    rank_sel;
    logic [WIDTH-1:0] arr    [N_PIXELS];
    logic [WIDTH-1:0] sorted [N_PIXELS];

`ifdef RANK_FILTER_RANK_SEL_EN
    // Requested rank, clamped to the top of the window.
    always_comb begin
        rank_sel = (RANK > LAST_IDX) ? LAST_IDX : RANK;
    end
`else
    // Rank selection disabled: RANK is kept on the port but always the median.
    logic unused_rank;
    assign unused_rank = ^RANK;

    always_comb begin
        rank_sel = MEDIAN_IDX;
    end
`endif

    // One odd-even transposition pass; pairs are disjoint, so all swaps read the pre-pass array.
    always_comb begin
        for (int i = 0; i < N_PIXELS; i++) begin
            sorted[i] = arr[i];
        end
        for (int i = 0; i + 1 < N_PIXELS; i++) begin
            if ((i[0] == pass_cnt[0]) && (arr[i] > arr[i+1])) begin
                sorted[i]   = arr[i+1];
                sorted[i+1] = arr[i];
            end
        end
    end

    // BUSY is a pure state decode, so the OUT cycle also ignores DSI.
    assign BUSY = (state != S_LOAD);

    // Window capture, sort sequencing and ranked output.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= S_LOAD;
            cnt      <= '0;
            pass_cnt <= '0;
            rank_q   <= '0;
            DO       <= '0;
            DSO      <= 1'b0;
            for (int i = 0; i < N_PIXELS; i++) begin
                arr[i] <= '0;
            end
        end else begin
            DSO <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (DSI) begin
                        arr[cnt] <= DI;
                        if (cnt == LAST_IDX) begin
                            cnt      <= '0;
                            rank_q   <= rank_sel;
                            pass_cnt <= '0;
                            state    <= S_SORT;
                        end else begin
                            cnt <= cnt + RW'(1);
                        end
                    end
                end
                S_SORT: begin
                    for (int i = 0; i < N_PIXELS; i++) begin
                        arr[i] <= sorted[i];
                    end
                    pass_cnt <= pass_cnt + PW'(1);
                    if (pass_cnt == LAST_PASS) begin
                        state <= S_OUT;
                    end
                end
                S_OUT: begin
                    DO    <= arr[rank_q];
                    DSO   <= 1'b1;
                    state <= S_LOAD;
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rank_filter.sv
// Bench for rank_filter: drives windows, predicts the ranked sample with a sorting model, and checks results via a scoreboard.
// Latency: every DSO is checked against N_PIXELS+1 edges after its last accepted sample.
// Backpressure: the source waits for BUSY low before each window; the busy scenario deliberately drives DSI during BUSY.
module tb_rank_filter;

    localparam int WIDTH = 8;
    localparam int N     = 9;
    localparam int RW    = $clog2(N);

    logic             CLK  = 1'b0;
    logic             nRST = 1'b0;
    logic             DSI  = 1'b0;
    logic [WIDTH-1:0] DI   = '0;
    logic [RW-1:0]    RANK = '0;
    logic [WIDTH-1:0] DO;
    logic             DSO;
    logic             BUSY;

    rank_filter #(.WIDTH(WIDTH), .N_PIXELS(N)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .DSI  (DSI),
        .DI   (DI),
        .RANK (RANK),
        .DO   (DO),
        .DSO  (DSO),
        .BUSY (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [WIDTH-1:0] val;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    int               vectors     = 0;
    int               miscompares = 0;
    int               cyc         = 0;
    bit               rst_edge    = 1'b1;
    logic [WIDTH-1:0] last_do     = '0;

    // Edge counter and "previous edge was a reset edge" flag.
    always @(posedge CLK) begin
        cyc      <= cyc + 1;
        rst_edge <= !nRST;
    end

    // Output monitor: scoreboard pop on DSO, otherwise DO must hold.
    always @(negedge CLK) begin
        exp_t e;
        if (DSO === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_dso: DO=%0d, no window pending", DO);
            end else begin
                e = sb.pop_front();
                if (DO !== e.val) begin
                    miscompares++;
                    $display("FAIL result: DO=%0d expected %0d", DO, e.val);
                end
                vectors++;
                if (cyc - e.cyc != N + 1) begin
                    miscompares++;
                    $display("FAIL latency: %0d edges expected %0d", cyc - e.cyc, N + 1);
                end
            end
        end else if (!rst_edge) begin
            vectors++;
            if (DO !== last_do) begin
                miscompares++;
                $display("FAIL do_hold: DO=%0d expected held %0d", DO, last_do);
            end
        end
        if (DSO === 1'b1 || rst_edge) last_do = DO;
    end

    // Reference: full sort, then pick the (clamped or median) rank.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] w[N], input int r);
        logic [WIDTH-1:0] s[N];
        logic [WIDTH-1:0] t;
        int               k;
        s = w;
        for (int a = 0; a < N; a++) begin
            for (int b = 0; b + 1 < N - a; b++) begin
                if (s[b] > s[b+1]) begin
                    t      = s[b];
                    s[b]   = s[b+1];
                    s[b+1] = t;
                end
            end
        end
`ifdef RANK_FILTER_RANK_SEL_EN
        k = (r > N - 1) ? N - 1 : r;
`else
        k = (N - 1) / 2;
`endif
        return s[k];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY !== 1'b0 && n < 50) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 50) begin
            miscompares++;
            $display("FAIL busy_timeout: BUSY=%b after %0d cycles, expected 0", BUSY, n);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (2) tick();
    endtask

    // Sends one window with `gap` idle cycles between samples; RANK is scrambled after capture.
    task automatic send_window(input logic [WIDTH-1:0] w[N], input int r, input int gap, input bit expect_out);
        exp_t e;
        wait_idle();
        RANK = RW'(r);
        for (int k = 0; k < N; k++) begin
            DSI = 1'b1;
            DI  = w[k];
            tick();
            DSI = 1'b0;
            if (k != N - 1) repeat (gap) tick();
        end
        RANK = ~RANK;
        if (expect_out) begin
            e.val = model(w, r);
            e.cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        DSI  = 1'b1;
        DI   = 8'hAA;
        repeat (3) tick();
        vectors++;
        if (DO !== 8'd0) begin miscompares++; $display("FAIL reset_do: DO=%0d expected 0", DO); end
        vectors++;
        if (DSO !== 1'b0) begin miscompares++; $display("FAIL reset_dso: DSO=%b expected 0", DSO); end
        vectors++;
        if (BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_busy: BUSY=%b expected 0", BUSY); end
        DSI  = 1'b0;
        nRST = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_median();
        logic [WIDTH-1:0] w[N];
        w = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
        send_window(w, 4, 0, 1'b1);
        drain();
        vectors++;
        if (DO !== 8'd5) begin miscompares++; $display("FAIL median: DO=%0d expected 5", DO); end
    endtask

    task automatic test_rank_clamp();
        logic [WIDTH-1:0] w[N];
        int               ranks[4];
        w     = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
        ranks = '{0, 8, 15, 3};
        foreach (ranks[i]) begin
            send_window(w, ranks[i], 0, 1'b1);
            drain();
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] w[N];
        int               busy_cycles = 0;
        int               n = 0;
        w = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd7, 8'd3, 8'd6, 8'd4, 8'd5};
        send_window(w, 4, 0, 1'b1);
        while (BUSY === 1'b1 && n < 40) begin
            busy_cycles++;
            DSI = 1'b1;
            DI  = WIDTH'(200 + n);
            tick();
            n++;
        end
        DSI = 1'b0;
        vectors++;
        if (busy_cycles != N + 1) begin
            miscompares++;
            $display("FAIL busy_len: BUSY high %0d cycles expected %0d", busy_cycles, N + 1);
        end
        drain();
        send_window(w, 0, 0, 1'b1);
        drain();
    endtask

    task automatic test_gapped();
        logic [WIDTH-1:0] w[N];
        w = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255};
        send_window(w, 4, 2, 1'b1);
        drain();
        vectors++;
        if (DO !== 8'd255) begin miscompares++; $display("FAIL gapped: DO=%0d expected 255", DO); end
        w = '{default: 8'd7};
        send_window(w, 4, 1, 1'b1);
        drain();
    endtask

    task automatic test_reset_abort();
        logic [WIDTH-1:0] w[N];
        for (int k = 0; k < 5; k++) begin
            DSI = 1'b1;
            DI  = WIDTH'(100 + k);
            tick();
        end
        DSI  = 1'b0;
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        w = '{8'd16, 8'd10, 8'd18, 8'd12, 8'd14, 8'd11, 8'd17, 8'd13, 8'd15};
        send_window(w, 4, 0, 1'b1);
        drain();
        vectors++;
        if (DO !== 8'd14) begin miscompares++; $display("FAIL reset_abort: DO=%0d expected 14", DO); end
        // Reset mid-SORT: the monitor flags any DSO that follows.
        send_window(w, 4, 0, 1'b0);
        repeat (3) tick();
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        vectors++;
        if (BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_sort_busy: BUSY=%b expected 0", BUSY); end
        repeat (15) tick();
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] w[N];
        for (int t = 0; t < 6; t++) begin
            foreach (w[k]) w[k] = WIDTH'($urandom_range(0, 255));
            send_window(w, int'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 1'b1);
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_median();
        test_rank_clamp();
        test_back_to_back();
        test_gapped();
        test_reset_abort();
        test_random();
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
